param_up_down_counter: RTL and testbench
========================================

Name: param_up_down_counter

Overview:
- Parametrised successor to the team's 4-bit up/down counter. Adds configurable width, a programmable modulus (MAX_VAL), a wrap or saturate policy, clock enable, synchronous parallel load, a registered terminal-count pulse and sticky overflow/underflow flags.
- Used as the general-purpose event/position counter in datapath and timer blocks.

Parameters:
- WIDTH, 8, counter width in bits.
- MAX_VAL, 255, upper count limit (inclusive). Legal range is 1 to 2**WIDTH-1; anything else is illegal and must fail at elaboration.
- SATURATE, 0. 0 = wrap at the boundaries; 1 = hold at the boundaries.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, count enable.
- mode, input, 1, direction: 1 = up, 0 = down.
- load, input, 1, synchronous parallel load.
- load_val, input, WIDTH, value for parallel load.
- flag_clr, input, 1, clears the sticky flags.
- count, output, WIDTH, current count (registered).
- tc, output, 1, terminal-count pulse (registered, one cycle).
- ovf, output, 1, sticky overflow flag.
- unf, output, 1, sticky underflow flag.

Behaviour:
- Reset: rst=0 asynchronously forces count=0, tc=0, ovf=0, unf=0. Outputs hold these values while rst=0. Operation resumes at the first rising edge after rst=1.
- All other updates occur on the rising edge of clk. Every output is a flop; there are no combinational paths from inputs to outputs.
- Priority per edge: load, then en, then hold.
- Load (load=1):
  - count <= min(load_val, MAX_VAL); values above MAX_VAL are clipped to MAX_VAL.
  - tc <= 0. ovf and unf are unchanged. en and mode are ignored.
- Count up (load=0, en=1, mode=1):
  - count < MAX_VAL: count <= count+1, tc <= 0.
  - count == MAX_VAL, SATURATE=0: count <= 0, tc <= 1, ovf <= 1.
  - count == MAX_VAL, SATURATE=1: count holds MAX_VAL, tc <= 1, ovf <= 1.
- Count down (load=0, en=1, mode=0):
  - count > 0: count <= count-1, tc <= 0.
  - count == 0, SATURATE=0: count <= MAX_VAL, tc <= 1, unf <= 1.
  - count == 0, SATURATE=1: count holds 0, tc <= 1, unf <= 1.
- Idle (load=0, en=0): count holds, tc <= 0.
- tc timing: high for exactly one cycle, visible in the same cycle as the count update caused by the boundary event. Under continuous saturation attempts, tc stays high on every cycle with an attempt.
- Sticky flags:
  - ovf and unf stay set until flag_clr=1 at a clock edge.
  - If flag_clr and a new boundary event occur on the same edge, the set wins and the flag stays 1.
  - flag_clr does not affect count or tc.
- Direction change: mode is sampled every edge, so a reversal takes effect on the next enabled edge with no dead cycle.
- Range invariant: count never exceeds MAX_VAL by any path, including load. Arithmetic is WIDTH bits, and the boundary compare happens before increment/decrement, so no natural 2**WIDTH rollover occurs when MAX_VAL < 2**WIDTH-1.
- Reset mid-operation: asserting rst at any point, including during a load, an event or a tc pulse, immediately clears everything. No pending state survives reset.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0: release rst, en=1, mode=1, 12 edges -> count 1..9, 0, 1, 2. tc=1 only on the cycle count becomes 0. ovf=1 from then on.
- Same config: load=1, load_val=0, then en=1, mode=0 -> count 9 after the first down edge, tc=1, unf=1. Next edges give 8, 7 with tc=0.
- SATURATE=1, MAX_VAL=9: load 9, count up 3 edges -> count stays 9, tc=1 on all three edges, ovf=1. Then mode=0 -> 8, tc=0.
- load_val=15 with MAX_VAL=9 -> count=9. load=1 with en=1 on the same edge -> the load wins and the count does not change direction. en=0 for 5 edges -> count holds, tc=0.
- ovf=1, then flag_clr=1 on the same edge as a wrap 9->0 -> ovf stays 1. flag_clr=1 on a non-event edge -> ovf=0 and unf=0, count unaffected.
- Count to 6, drive rst=0 between clock edges -> count=0, tc=0, flags=0 immediately (asynchronous, no edge needed). Hold rst=0 across 3 edges with en=1 -> outputs stay 0. Release -> counts 1, 2, ...

Source files
------------

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with programmable modulus, wrap/saturate policy,
// parallel load, registered terminal-count pulse and sticky overflow/underflow flags.
module param_up_down_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = 255,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  // Reject configurations whose modulus cannot be represented or is empty.
  generate
    if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
      $error("param_up_down_counter: WIDTH must be in 1..63");
    end
    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max_val
      $error("param_up_down_counter: MAX_VAL must be in 1..2**WIDTH-1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_next;
  logic             unf_next;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == MAX_CNT);
  assign at_zero = (count == '0);

  // Boundary compare precedes the arithmetic, so count never walks past MAX_CNT.
  always_comb begin
    count_next = count;
    tc_next    = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (load) begin
      count_next = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    end else if (en) begin
      if (mode) begin
        if (!at_max) begin
          count_next = count + ONE;
        end else begin
          count_next = SATURATE ? MAX_CNT : '0;
          tc_next    = 1'b1;
          ovf_set    = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_next = count - ONE;
        end else begin
          count_next = SATURATE ? '0 : MAX_CNT;
          tc_next    = 1'b1;
          unf_set    = 1'b1;
        end
      end
    end
  end

  // A boundary event on the same edge as flag_clr keeps the flag set.
  assign ovf_next = ovf_set | (ovf & ~flag_clr);
  assign unf_next = unf_set | (unf & ~flag_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= tc_next;
      ovf   <= ovf_next;
      unf   <= unf_next;
    end
  end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Drives three counter configurations with shared directed and random stimulus and
// compares them against an arithmetic reference model.
module tb_param_up_down_counter;

  localparam int N = 3;
  // Config 0: wrap mod 10, config 1: saturate at 9, config 2: wrap over full 4-bit range.
  int cfg_max [N] = '{9, 9, 15};
  bit cfg_sat [N] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       flag_clr = 1'b0;

  logic [3:0] count_o [N];
  logic       tc_o    [N];
  logic       ovf_o   [N];
  logic       unf_o   [N];

  int m_count [N];
  int m_tc    [N];
  int m_ovf   [N];
  int m_unf   [N];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap9 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .flag_clr(flag_clr), .count(count_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0]));
  param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat9 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .flag_clr(flag_clr), .count(count_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1]));
  param_up_down_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) u_wrap16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .flag_clr(flag_clr), .count(count_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]), .unf(unf_o[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_count[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endtask

  // Effect of one rising edge with the inputs currently applied.
  task automatic model_edge();
    int step;
    int target;
    bit hit;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      hit = 1'b0;
      if (load) begin
        m_count[i] = (int'(load_val) > cfg_max[i]) ? cfg_max[i] : int'(load_val);
      end else if (en) begin
        step   = mode ? 1 : -1;
        target = m_count[i] + step;
        if (target > cfg_max[i] || target < 0) begin
          hit = 1'b1;
          if (!cfg_sat[i]) m_count[i] = (target > cfg_max[i]) ? 0 : cfg_max[i];
        end else begin
          m_count[i] = target;
        end
      end
      if (flag_clr) begin
        m_ovf[i] = 0; m_unf[i] = 0;
      end
      if (hit && mode) m_ovf[i] = 1;
      if (hit && !mode) m_unf[i] = 1;
      m_tc[i] = hit ? 1 : 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s.count[%0d]", tag, i), 32'(count_o[i]), 32'(m_count[i]));
      check($sformatf("%s.tc[%0d]", tag, i),    32'(tc_o[i]),    32'(m_tc[i]));
      check($sformatf("%s.ovf[%0d]", tag, i),   32'(ovf_o[i]),   32'(m_ovf[i]));
      check($sformatf("%s.unf[%0d]", tag, i),   32'(unf_o[i]),   32'(m_unf[i]));
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    $display("[%0t] %s rst=%0b ld=%0b lv=%0d en=%0b up=%0b clr=%0b -> cnt=%0d/%0d/%0d tc=%0b%0b%0b",
             $time, tag, rst, load, load_val, en, mode, flag_clr,
             count_o[0], count_o[1], count_o[2], tc_o[0], tc_o[1], tc_o[2]);
  endtask

  task automatic set_in(input bit l, input int lv, input bit e, input bit m, input bit c);
    load = l; load_val = 4'(lv); en = e; mode = m; flag_clr = c;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    check("reset.const_count", 32'(count_o[0]), 32'd0);

    // Free-run up through the modulus boundary.
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(0, 0, 1, 1, 0);
    for (int k = 0; k < 12; k++) begin
      tick("up");
      check("up.const_count", 32'(count_o[0]), 32'((k + 1) % 10));
      check("up.const_tc", 32'(tc_o[0]), 32'(k == 9));
    end
    check("up.const_ovf", 32'(ovf_o[0]), 32'd1);

    // Underflow wrap from zero.
    set_in(1, 0, 0, 0, 0); tick("load0");
    set_in(0, 0, 1, 0, 0); tick("down_wrap");
    check("down_wrap.count", 32'(count_o[0]), 32'd9);
    check("down_wrap.unf", 32'(unf_o[0]), 32'd1);
    tick("down8");
    check("down8.count", 32'(count_o[0]), 32'd8);
    tick("down7");
    check("down7.tc", 32'(tc_o[0]), 32'd0);

    // Saturation at the top, then reversal.
    set_in(1, 9, 0, 0, 0); tick("load9");
    set_in(0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick("sat_up");
      check("sat_up.count", 32'(count_o[1]), 32'd9);
      check("sat_up.tc", 32'(tc_o[1]), 32'd1);
    end
    set_in(0, 0, 1, 0, 0); tick("sat_rev");
    check("sat_rev.count", 32'(count_o[1]), 32'd8);
    check("sat_rev.tc", 32'(tc_o[1]), 32'd0);

    // Load clipping, load priority over enable, idle hold.
    set_in(1, 15, 0, 0, 0); tick("clip");
    check("clip.count", 32'(count_o[0]), 32'd9);
    check("clip.full", 32'(count_o[2]), 32'd15);
    set_in(1, 3, 1, 0, 0); tick("load_pri");
    check("load_pri.count", 32'(count_o[0]), 32'd3);
    set_in(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) tick("idle");
    check("idle.count", 32'(count_o[0]), 32'd3);

    // Set beats clear on the same edge; plain clear on a quiet edge.
    set_in(1, 9, 0, 0, 0); tick("load9b");
    set_in(0, 0, 1, 1, 1); tick("clr_vs_set");
    check("clr_vs_set.ovf", 32'(ovf_o[0]), 32'd1);
    set_in(0, 0, 0, 1, 1); tick("clr");
    check("clr.ovf", 32'(ovf_o[0]), 32'd0);
    check("clr.unf", 32'(unf_o[0]), 32'd0);

    // Asynchronous reset between edges, held across enabled edges.
    set_in(1, 0, 0, 0, 0); tick("load0b");
    set_in(0, 0, 1, 1, 0);
    for (int k = 0; k < 6; k++) tick("to6");
    check("to6.count", 32'(count_o[0]), 32'd6);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.count", 32'(count_o[0]), 32'd0);
    for (int k = 0; k < 3; k++) tick("rst_hold");
    rst = 1'b1;
    tick("rel1");
    check("rel1.count", 32'(count_o[0]), 32'd1);
    tick("rel2");
    check("rel2.count", 32'(count_o[0]), 32'd2);

    // Randomised traffic with occasional mid-cycle resets.
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 11) == 0);
      tick("rand");
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b0;
        model_reset();
        #1 check_all("rand_rst");
        rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
